lsu_ctrl: RTL and testbench

Load/store sequencing controller between the execute stage and the data memory of the RISC-V core. Accepts one load or store request at a time and drives a variable-latency memory through a req/ack handshake. Generates byte enables and lane-replicated store data, then extracts and sign- or zero-extends load data. Stalls the pipeline until the access completes, errors, or times out.

---
 rtl/lsu_if.sv | 38 +++
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if: request/response and data-memory signals of the load/store unit.
// slave is the controller side; master is the pipeline/memory side.
interface lsu_if #(
    parameter int CPU_WORD   = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [CPU_WORD-1:0]   req_wdata;
    logic                  resp_valid;
    logic [CPU_WORD-1:0]   resp_rdata;
    logic                  resp_err;
    logic                  stall;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [CPU_WORD-1:0]   mem_wdata;
    logic                  mem_ack;
    logic [CPU_WORD-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer with req/ack memory handshake and timeout.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned lh/lhu/sh/lw/sw into errors.
module lsu_ctrl #(
    parameter int CPU_WORD   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input logic clk,
    input logic rst_n,
    lsu_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          state;
    logic [7:0]          cnt;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [1:0]          addr_q;
    logic                err_q;
    logic [CPU_WORD-1:0] rdata_q;

    logic                illegal;
    logic                misal;
    logic [3:0]          be_n;
    logic [CPU_WORD-1:0] wd_n;
    logic [7:0]          ld_b;
    logic [15:0]         ld_h;
    logic [CPU_WORD-1:0] ld_ext;

    always_comb begin
        if (bus.req_we)
            illegal = bus.req_funct3 > 3'b010;
        else
            illegal = (bus.req_funct3 == 3'b011) ||
                      (bus.req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_funct3[1:0] == 2'b10) &&
                 (bus.req_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
    end

    // Store lanes are computed at accept so ACCESS sees stable registers.
    always_comb begin
        be_n = 4'b0000;
        wd_n = '0;
        if (bus.req_we) begin
            unique case (1'b1)
                (bus.req_funct3[1:0] == 2'b00): begin
                    be_n = 4'b0001 << bus.req_addr[1:0];
                    wd_n = {4{bus.req_wdata[7:0]}};
                end
                (bus.req_funct3[1:0] == 2'b01): begin
                    be_n = 4'b0011 << {bus.req_addr[1], 1'b0};
                    wd_n = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    be_n = 4'b1111;
                    wd_n = bus.req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        ld_b = bus.mem_rdata[{addr_q, 3'b000} +: 8];
        ld_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        unique case (1'b1)
            (f3_q == 3'b000): ld_ext = {{24{ld_b[7]}}, ld_b};
            (f3_q == 3'b001): ld_ext = {{16{ld_h[15]}}, ld_h};
            (f3_q == 3'b100): ld_ext = {24'd0, ld_b};
            (f3_q == 3'b101): ld_ext = {16'd0, ld_h};
            default:          ld_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            we_q          <= 1'b0;
            f3_q          <= 3'd0;
            addr_q        <= 2'd0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= 4'b0000;
            bus.mem_wdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q   <= bus.req_we;
                        f3_q   <= bus.req_funct3;
                        addr_q <= bus.req_addr[1:0];
                        if (illegal || misal) begin
                            state   <= S_RESP;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state         <= S_ACCESS;
                            cnt           <= 8'd0;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.mem_be    <= be_n;
                            bus.mem_wdata <= wd_n;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_ack) begin
                        state   <= S_RESP;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : ld_ext;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state   <= S_RESP;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.stall      = (state != S_IDLE);
    assign bus.mem_req    = (state == S_ACCESS);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_err   = (state == S_RESP) && err_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl built with TIMEOUT=4.
// Expected responses are queued at request time and popped at resp_valid.
module tb_lsu_ctrl;
    logic clk;
    logic rst_n;

    lsu_if #(.CPU_WORD(32), .ADDR_WIDTH(32)) bus ();

    lsu_ctrl #(
        .CPU_WORD(32),
        .ADDR_WIDTH(32),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    int errors = 0;
    int checks = 0;

    int          got_lat;
    int          got_mreq;
    int          got_stall;
    logic        got_rdy;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] got_maddr;
    logic [3:0]  got_mbe;
    logic [31:0] got_mwdata;
    logic        got_mwe;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 after RESP.
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_after, input logic [31:0] rdata);
        got_lat = 0; got_mreq = 0; got_stall = 0; got_rdy = 1'bx;
        got_rdata = 'x; got_err = 1'bx;
        got_maddr = 'x; got_mbe = 'x; got_mwdata = 'x; got_mwe = 1'bx;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.mem_rdata = rdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.mem_ack = (ack_after >= 0) && (cyc == ack_after + 1);
            @(negedge clk);
            if (bus.stall) got_stall++;
            if (bus.mem_req) begin
                if (got_mreq == 0) begin
                    got_maddr = bus.mem_addr; got_mbe = bus.mem_be;
                    got_mwdata = bus.mem_wdata; got_mwe = bus.mem_we;
                end
                got_mreq++;
            end
            if (bus.resp_valid) begin
                got_lat = cyc; got_rdata = bus.resp_rdata;
                got_err = bus.resp_err; got_rdy = bus.req_ready;
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (got_lat != 0) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready);
        end
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.stall, bus.mem_req, bus.mem_we,
             bus.mem_be, bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_outputs got=%b%b%b%b%b %h %h %h %h exp=all zero",
                     bus.resp_valid, bus.resp_err, bus.stall, bus.mem_req,
                     bus.mem_we, bus.mem_be, bus.resp_rdata, bus.mem_addr,
                     bus.mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_zero_wait;
        sbq.push_back('{32'hDEADBEEF, 1'b0});
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        e = sbq.pop_front();
        checks++;
        if ({got_rdata, got_err} !== {e.rdata, e.err}) begin
            errors++; $display("FAIL lw_resp got=%h/%b exp=%h/%b",
                               got_rdata, got_err, e.rdata, e.err);
        end
        checks++;
        if (got_lat !== 2) begin
            errors++; $display("FAIL lw_latency got=%0d exp=2", got_lat);
        end
        checks++;
        if (got_stall !== 2) begin
            errors++; $display("FAIL lw_stall got=%0d exp=2", got_stall);
        end
        checks++;
        if ({got_maddr, got_mbe, got_mwe} !== {32'h100, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL lw_mem got=%h %b %b exp=00000100 0000 0",
                               got_maddr, got_mbe, got_mwe);
        end
        checks++;
        if (got_rdy !== 1'b0) begin
            errors++; $display("FAIL resp_ready got=%b exp=0", got_rdy);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s[4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{exps[i], 1'b0});
            run_access(1'b0, f3s[i], ads[i], 32'h0, 3, 32'h80FF1234);
            e = sbq.pop_front();
            checks++;
            if ({got_rdata, got_err} !== {e.rdata, e.err}) begin
                errors++; $display("FAIL load%0d_resp got=%h/%b exp=%h/%b",
                                   i, got_rdata, got_err, e.rdata, e.err);
            end
            checks++;
            if (got_lat !== 5) begin
                errors++; $display("FAIL load%0d_latency got=%0d exp=5", i, got_lat);
            end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s[3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ads[3] = '{32'h202, 32'h101, 32'h300};
        logic [31:0] wds[3] = '{32'h0000ABCD, 32'h123456EF, 32'hCAFEF00D};
        logic [31:0] ema[3] = '{32'h200, 32'h100, 32'h300};
        logic [3:0]  ebe[3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ewd[3] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{32'h0, 1'b0});
            run_access(1'b1, f3s[i], ads[i], wds[i], 1, 32'h12345678);
            e = sbq.pop_front();
            checks++;
            if ({got_rdata, got_err} !== {e.rdata, e.err}) begin
                errors++; $display("FAIL st%0d_resp got=%h/%b exp=%h/%b",
                                   i, got_rdata, got_err, e.rdata, e.err);
            end
            checks++;
            if ({got_maddr, got_mbe, got_mwdata, got_mwe} !==
                {ema[i], ebe[i], ewd[i], 1'b1}) begin
                errors++; $display("FAIL st%0d_mem got=%h %b %h %b exp=%h %b %h 1",
                                   i, got_maddr, got_mbe, got_mwdata, got_mwe,
                                   ema[i], ebe[i], ewd[i]);
            end
        end
    endtask

    task automatic test_timeout;
        sbq.push_back('{32'h0, 1'b1});
        run_access(1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h11111111);
        e = sbq.pop_front();
        checks++;
        if ({got_rdata, got_err} !== {e.rdata, e.err}) begin
            errors++; $display("FAIL to_resp got=%h/%b exp=%h/%b",
                               got_rdata, got_err, e.rdata, e.err);
        end
        checks++;
        if ({got_lat, got_mreq} !== {32'd5, 32'd4}) begin
            errors++; $display("FAIL to_timing got=lat%0d req%0d exp=lat5 req4",
                               got_lat, got_mreq);
        end
        sbq.push_back('{32'h55AA55AA, 1'b0});
        run_access(1'b0, 3'b010, 32'h404, 32'h0, 3, 32'h55AA55AA);
        e = sbq.pop_front();
        checks++;
        if ({got_rdata, got_err, got_lat} !== {e.rdata, e.err, 32'd5}) begin
            errors++; $display("FAIL to_lastack got=%h/%b lat%0d exp=%h/%b lat5",
                               got_rdata, got_err, got_lat, e.rdata, e.err);
        end
    endtask

    task automatic test_illegal;
        logic       wes[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] f3s[5] = '{3'b011, 3'b110, 3'b111, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{32'h0, 1'b1});
            run_access(wes[i], f3s[i], 32'h500, 32'hFFFFFFFF, 0, 32'h9999);
            e = sbq.pop_front();
            checks++;
            if ({got_rdata, got_err, got_lat, got_mreq} !==
                {e.rdata, e.err, 32'd1, 32'd0}) begin
                errors++; $display("FAIL illegal%0d got=%h/%b lat%0d req%0d exp=%h/%b lat1 req0",
                                   i, got_rdata, got_err, got_lat, got_mreq,
                                   e.rdata, e.err);
            end
        end
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
        sbq.push_back('{32'h0, 1'b1});
        run_access(1'b0, 3'b001, 32'h301, 32'h0, 0, 32'h12348765);
        e = sbq.pop_front();
        checks++;
        if ({got_rdata, got_err, got_lat, got_mreq} !==
            {e.rdata, e.err, 32'd1, 32'd0}) begin
            errors++; $display("FAIL mis_lh got=%h/%b lat%0d req%0d exp=%h/%b lat1 req0",
                               got_rdata, got_err, got_lat, got_mreq, e.rdata, e.err);
        end
`else
        sbq.push_back('{32'hFFFF8765, 1'b0});
        run_access(1'b0, 3'b001, 32'h301, 32'h0, 0, 32'h12348765);
        e = sbq.pop_front();
        checks++;
        if ({got_rdata, got_err, got_lat, got_maddr} !==
            {e.rdata, e.err, 32'd2, 32'h300}) begin
            errors++; $display("FAIL mis_lh got=%h/%b lat%0d %h exp=%h/%b lat2 00000300",
                               got_rdata, got_err, got_lat, got_maddr, e.rdata, e.err);
        end
        sbq.push_back('{32'h0, 1'b0});
        run_access(1'b1, 3'b010, 32'h203, 32'hA5A5A5A5, 0, 32'h0);
        e = sbq.pop_front();
        checks++;
        if ({got_err, got_maddr, got_mbe} !== {e.err, 32'h200, 4'b1111}) begin
            errors++; $display("FAIL mis_sw got=%b %h %b exp=%b 00000200 1111",
                               got_err, got_maddr, got_mbe, e.err);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h600; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++; $display("FAIL mid_req_pre got=%b exp=1", bus.mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.req_ready, bus.stall} !== 3'b010) begin
            errors++; $display("FAIL mid_reset got=req%b rdy%b stall%b exp=req0 rdy1 stall0",
                               bus.mem_req, bus.req_ready, bus.stall);
        end
        @(negedge clk); rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        bus.mem_ack = 1'b0;
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL mid_late_ack got=%0d exp=0", pulses);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        for (int i = 0; i < 4; i++) sbq.push_back('{32'h0BADF00D, 1'b0});
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h700; bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.resp_valid) begin
                pulses++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got=resp exp=none");
                end else begin
                    e = sbq.pop_front();
                    if ({bus.resp_rdata, bus.resp_err} !== {e.rdata, e.err}) begin
                        errors++; $display("FAIL b2b_resp got=%h/%b exp=%h/%b",
                                           bus.resp_rdata, bus.resp_err, e.rdata, e.err);
                    end
                end
            end
            if (cyc == 12) begin
                bus.req_valid = 1'b0; bus.mem_ack = 1'b0;
            end
        end
        checks++;
        if (pulses !== 4 || sbq.size() !== 0) begin
            errors++; $display("FAIL b2b_count got=%0d left%0d exp=4 left0",
                               pulses, sbq.size());
        end
        sbq.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset;
        test_lw_zero_wait;
        test_loads;
        test_stores;
        test_timeout;
        test_illegal;
        test_misalign;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
